// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Holds the memory-responder FSM state type and defaults, together with the
// CPU opcode and CPU state constants that the rest of the CPU uses.
package cpu_pkg;

  // Memory responder defaults
  localparam int unsigned CPU_WAIT_STATES_DEF = 1;
  localparam logic [7:0]  CPU_IO_PORT_DEF     = 8'hFF;

  // Memory responder FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    IO_WAIT = 2'd2,
    RESP    = 2'd3
  } mem_state_t;

  // CPU opcodes
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LD  = 4'h1,
    OP_ST  = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_JMP = 4'h5,
    OP_JZ  = 4'h6,
    OP_HLT = 4'hF
  } cpu_op_t;

  // CPU core states
  typedef enum logic [1:0] {
    CPU_FETCH  = 2'd0,
    CPU_DECODE = 2'd1,
    CPU_EXEC   = 2'd2,
    CPU_HALT   = 2'd3
  } cpu_state_t;

  function automatic logic is_io_addr(input logic [7:0] addr,
                                      input logic [7:0] io_port);
    return addr == io_port;
  endfunction

endpackage

// File: rtl/cpu_ram_256x8.sv
// 256 x 8 RAM: synchronous write, registered read, no reset.
// Ports:
//   clk   - clock
//   we    - write enable (writes wdata to addr on rising edge)
//   re    - read enable (loads rdata from addr on rising edge)
//   addr  - byte address
//   wdata - write data
//   rdata - registered read data
module cpu_ram_256x8 (
  input  logic       clk,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_mem_resp.sv
// CPU bus responder: RAM with configurable wait states plus one I/O port.
// Ports:
//   clk, reset_n                      - clock, async active-low reset
//   req_valid/req_we/req_addr/req_wdata, req_ready - request channel
//   rsp_valid/rsp_rdata, rsp_ready    - response channel
//   io_out_valid/io_out_data          - output strobe and data for IO_PORT writes
//   io_in_valid/io_in_data            - external input for IO_PORT reads
//   busy                              - high whenever the FSM is not IDLE
module cpu_mem_resp
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_STATES = CPU_WAIT_STATES_DEF,
  parameter logic [7:0]  IO_PORT     = CPU_IO_PORT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       rsp_ready,
  output logic       io_out_valid,
  output logic [7:0] io_out_data,
  input  logic       io_in_valid,
  input  logic [7:0] io_in_data,
  output logic       busy
);

  mem_state_t state, state_d;
  logic [2:0] cnt, cnt_d;
  logic       we_q;
  logic [7:0] addr_q, wdata_q;
  logic [7:0] rdata_q;
  logic       use_ram_q;

  logic       accept, enter_resp;
  logic       cur_we;
  logic [7:0] cur_addr, cur_wdata;
  logic       cur_io;
  logic       ram_we, ram_re;
  logic [7:0] ram_q;

  // In IDLE the transaction is still on the req_* inputs; afterwards it lives
  // in the latched copies. This lets zero-wait RAM and I/O writes complete on
  // the accept edge itself.
  always_comb begin
    cur_we     = (state == IDLE) ? req_we    : we_q;
    cur_addr   = (state == IDLE) ? req_addr  : addr_q;
    cur_wdata  = (state == IDLE) ? req_wdata : wdata_q;
    cur_io     = is_io_addr(cur_addr, IO_PORT);
    state_d    = state;
    cnt_d      = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (cur_io) begin
            if (req_we) begin
              state_d    = RESP;
              enter_resp = 1'b1;
            end else begin
              state_d = IO_WAIT;
            end
          end else if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        cnt_d = (cnt != 3'd0) ? cnt - 3'd1 : 3'd0;
        if (cnt <= 3'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      IO_WAIT: begin
        if (io_in_valid) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ram_we = enter_resp && !cur_io && cur_we;
    ram_re = enter_resp && !cur_io && !cur_we;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      use_ram_q    <= 1'b0;
      io_out_valid <= 1'b0;
      io_out_data  <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      io_out_valid <= 1'b0;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        if (state == IO_WAIT) begin
          rdata_q   <= io_in_data;
          use_ram_q <= 1'b0;
        end else if (cur_we) begin
          rdata_q   <= cur_wdata;
          use_ram_q <= 1'b0;
          if (cur_io) begin
            io_out_valid <= 1'b1;
            io_out_data  <= cur_wdata;
          end
        end else begin
          use_ram_q <= 1'b1;
        end
      end
    end
  end

  cpu_ram_256x8 u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cur_addr),
    .wdata (cur_wdata),
    .rdata (ram_q)
  );

  // RAM read data comes straight from the RAM's output register, which only
  // reloads on entry to RESP, so it stays stable while the response is held.
  assign rsp_rdata = use_ram_q ? ram_q : rdata_q;
  assign rsp_valid = (state == RESP);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/cpu_mem_resp.md
CPU_MEM_RESP -- requirements
Module: cpu_mem_resp

Interface
REQ-001 Parameter WAIT_STATES, default 1, is the number of extra cycles before a memory response (legal range 0-7).
REQ-002 Parameter IO_PORT, default 8'hFF, is the single address mapped to the I/O port instead of RAM.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  CPU presents a bus request.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  8  byte address.
REQ-008 req_wdata  input  8  write data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_rdata  output  8  read data; for writes, the written byte echoed back.
REQ-012 rsp_ready  input  1  CPU accepts the response.
REQ-013 io_out_valid  output  1  one-cycle strobe for a write to IO_PORT.
REQ-014 io_out_data  output  8  byte written to IO_PORT; holds its value until the next I/O write.
REQ-015 io_in_valid  input  1  external device presents input data.
REQ-016 io_in_data  input  8  external input byte.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, WAIT, IO_WAIT and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on any edge where req_valid and req_ready are both 1.
REQ-020 On acceptance the block SHALL latch req_we, req_addr and req_wdata; later changes on the req_* inputs SHALL have no effect on the transaction.
REQ-021 For a RAM request (req_addr != IO_PORT), IDLE SHALL go to WAIT, loading the wait counter with WAIT_STATES.
- With WAIT_STATES = 0, IDLE goes directly to RESP.
- Net effect: rsp_valid rises exactly WAIT_STATES+1 cycles after the accept edge.
REQ-022 In WAIT the counter SHALL decrement each cycle; the FSM goes to RESP on the cycle the counter reaches 0.
REQ-023 A RAM write SHALL update the array on the edge that enters RESP; a RAM read SHALL sample the array on that same edge.
REQ-024 A write to IO_PORT SHALL do all of the following, with no wait states:
- pulse io_out_valid for exactly one cycle, coincident with entry to RESP;
- load io_out_data;
- go to RESP.
REQ-025 A read from IO_PORT SHALL enter IO_WAIT and stay there until io_in_valid = 1. It then captures io_in_data into rsp_rdata and goes to RESP. There is no timeout.
REQ-026 In RESP, rsp_valid and rsp_rdata SHALL be held stable until rsp_ready = 1; on that edge the FSM returns to IDLE.
REQ-027 If rsp_ready is already 1 on RESP entry, RESP SHALL last exactly one cycle.
REQ-028 A new request SHALL NOT be accepted in the cycle the response is consumed; the earliest next accept is the following cycle, in IDLE.
REQ-029 io_in_valid asserted outside IO_WAIT SHALL be ignored.
REQ-030 RAM address IO_PORT SHALL be unreachable; the other 255 locations behave as plain RAM.

Reset
REQ-031 Asserting reset_n low SHALL immediately force the following, including mid-transaction (the pending transaction is dropped):
- state = IDLE, wait counter = 0;
- rsp_valid = 0, rsp_rdata = 8'h00;
- io_out_valid = 0, io_out_data = 8'h00;
- busy = 0 (req_ready follows from IDLE).
REQ-032 RAM contents SHALL NOT be reset; they are preserved across reset and undefined after power-up.

Structure
REQ-033 The state enum, IO_PORT default and WAIT_STATES default SHALL live in shared package cpu_pkg, alongside the CPU opcode and state constants.
REQ-034 RAM storage SHALL be a sub-module, cpu_ram_256x8: synchronous write, registered read, no reset.

Verification
REQ-035 Reset, then with WAIT_STATES = 1: write 8'hA5 to 8'h10, then read 8'h10 -> write response echoes A5; read rsp_rdata = A5; each rsp_valid rises 2 cycles after its accept edge.
REQ-036 With WAIT_STATES = 0: read 8'h10 with rsp_ready tied 1 -> rsp_valid is high for exactly one cycle, 1 cycle after accept; req_ready is low on the response cycle.
REQ-037 Write 8'h3C to 8'hFF -> io_out_valid pulses once with io_out_data = 3C; RAM location 8'hFE is unchanged.
REQ-038 Read 8'hFF with io_in_valid held low for 5 cycles, then io_in_data = 8'h7E with io_in_valid = 1 -> busy stays high throughout; rsp_rdata = 7E the next cycle.
REQ-039 Hold rsp_ready low for 4 cycles after rsp_valid while toggling req_* inputs -> rsp_rdata stays stable and no new request is accepted.
REQ-040 Pull reset_n low during WAIT of a write of 8'h55 to 8'h20 -> rsp_valid = 0 and state = IDLE immediately; a subsequent read of 8'h20 returns the pre-reset contents, not 55.
